// File: rtl/conv1d_stream_engine.sv
// Streaming 1-D convolution of one pixel row through a run-time-loadable TAPS-wide kernel,
// with valid/ready handshakes on both sides and an optional ReLU output clamp.
module conv1d_stream_engine #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TAPS    = 3,
    parameter int unsigned ROW_LEN = 32,
    parameter int unsigned OUT_W   = 18,
    localparam int unsigned IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic signed [DATA_W-1:0] cfg_weight,
    input  logic                     relu_en,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CNT_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                   r_state, w_state_next;
    logic signed [DATA_W-1:0] r_w   [TAPS];
    logic signed [DATA_W-1:0] r_win [TAPS-1];
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_relu;
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_out_data;
    logic                     r_out_last;

    logic                     w_accept, w_push, w_pop, w_last_pix;
    logic signed [DATA_W-1:0] w_x    [TAPS];
    logic signed [PROD_W-1:0] w_prod [TAPS];
    logic signed [OUT_W-1:0]  w_sum, w_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun:   if (w_accept && w_last_pix) w_state_next = StDrain;
            StDrain: if (!r_out_valid || out_ready) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (r_state == StRun) && (!r_out_valid || out_ready);
        busy     = (r_state != StIdle);
        done     = (r_state == StDone);
    end

    assign w_accept   = in_valid && in_ready;
    assign w_last_pix = (r_cnt == CNT_W'(ROW_LEN - 1));
    assign w_push     = w_accept && (32'(r_cnt) >= TAPS - 1);
    assign w_pop      = r_out_valid && out_ready;

    // Oldest tap is x[j]; the incoming pixel completes the window as x[j+TAPS-1].
    always_comb begin
        w_x[TAPS-1] = in_data;
        for (int k = 0; k < int'(TAPS) - 1; k++) w_x[k] = r_win[k];
        w_sum = '0;
        for (int k = 0; k < int'(TAPS); k++) begin
            w_prod[k] = {{DATA_W{r_w[k][DATA_W-1]}}, r_w[k]} *
                        {{DATA_W{w_x[k][DATA_W-1]}}, w_x[k]};
            w_sum = w_sum + {{(OUT_W - PROD_W){w_prod[k][PROD_W-1]}}, w_prod[k]};
        end
        w_result = (r_relu && w_sum[OUT_W-1]) ? '0 : w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(TAPS); k++) r_w[k] <= '0;
            for (int k = 0; k < int'(TAPS) - 1; k++) r_win[k] <= '0;
            r_cnt       <= '0;
            r_relu      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_state == StIdle) begin
                if (cfg_we && (32'(cfg_idx) < TAPS)) r_w[cfg_idx] <= cfg_weight;
                if (start) begin
                    for (int k = 0; k < int'(TAPS) - 1; k++) r_win[k] <= '0;
                    r_cnt  <= '0;
                    r_relu <= relu_en;
                end
            end
            if (w_accept) begin
                for (int k = 0; k < int'(TAPS) - 2; k++) r_win[k] <= r_win[k+1];
                r_win[TAPS-2] <= in_data;
                r_cnt         <= r_cnt + CNT_W'(1);
            end
            // A push in the same cycle as a pop simply reloads the register.
            if (w_push) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
                r_out_last  <= w_last_pix;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_conv1d_stream_engine.sv
// Self-checking bench for conv1d_stream_engine: table-driven rows with constant spot values,
// randomized rows against an arithmetic reference model, and hand-written corner sequences.
module tb_conv1d_stream_engine;

    localparam int TAPS    = 3;
    localparam int ROW_LEN = 32;
    localparam int NRES    = ROW_LEN - TAPS + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [1:0]        cfg_idx;
    logic signed [7:0] cfg_weight;
    logic              relu_en;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [17:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    conv1d_stream_engine #(
        .DATA_W  (8),
        .TAPS    (TAPS),
        .ROW_LEN (ROW_LEN),
        .OUT_W   (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_weight (cfg_weight),
        .relu_en    (relu_en),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w0, w1, w2;
        int pat;   // 0 ramp, 1 impulse at 10, 2 constant -128
        bit relu;
        int j0, v0, j1, v1, j2, v2;
    } vec_t;

    vec_t vecs[5];
    int   mw[TAPS];
    int   pix[ROW_LEN];
    int   exp_res[NRES];
    int   got[NRES];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"},  int'(in_ready), 0);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " out_data"},  int'($signed(out_data)), 0);
        check({tag, " out_last"},  int'(out_last), 0);
        check({tag, " busy"},      int'(busy), 0);
        check({tag, " done"},      int'(done), 0);
    endtask

    task automatic write_w(input int idx, input int val);
        @(negedge clk);
        cfg_we     = 1'b1;
        cfg_idx    = 2'(idx);
        cfg_weight = 8'(val);
        @(negedge clk);
        cfg_we = 1'b0;
        if (idx < TAPS) mw[idx] = val;
    endtask

    task automatic set_pix(input int pat);
        for (int i = 0; i < ROW_LEN; i++) begin
            case (pat)
                0:       pix[i] = i;
                1:       pix[i] = (i == 10) ? 100 : 0;
                2:       pix[i] = -128;
                default: pix[i] = int'($urandom_range(255)) - 128;
            endcase
        end
    endtask

    // Runs one row. gap/ordy are percentages of idle in_valid / low out_ready cycles.
    task automatic run_row(input bit relu, input int gap_pct, input int ordy_pct,
                           input int stall_at, input int inject_at, input int rst_after);
        int  idx, nres, s, od;
        bit  seen_done, aborted, full;
        full = (gap_pct == 0) && (ordy_pct == 0) && (stall_at < 0);
        for (int j = 0; j < NRES; j++) begin
            s = 0;
            for (int k = 0; k < TAPS; k++) s += mw[k] * pix[j + k];
            if (relu && s < 0) s = 0;
            exp_res[j] = s;
            got[j]     = 32'hdead;
        end
        @(negedge clk);
        start   = 1'b1;
        relu_en = relu;
        idx = 0; nres = 0; seen_done = 1'b0; aborted = 1'b0;
        // Loop iteration n observes the cycle n after the start cycle.
        for (int cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
            @(negedge clk);
            start      = (cyc == inject_at);
            cfg_we     = (cyc == inject_at);
            cfg_idx    = 2'd1;
            cfg_weight = 8'sd5;
            if (rst_after >= 0 && idx == rst_after + 1) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < TAPS; k++) mw[k] = 0;
                aborted = 1'b1;
                break;
            end
            in_valid = (idx < ROW_LEN) && (int'($urandom_range(99)) >= gap_pct);
            in_data  = (idx < ROW_LEN) ? 8'(pix[idx]) : 8'sd0;
            out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) &&
                        (int'($urandom_range(99)) >= ordy_pct);
            #1;
            if (cyc == 1) check("busy_after_start", int'(busy), 1);
            if (cyc == 1 && full) check("in_ready_after_start", int'(in_ready), 1);
            if (out_valid && !out_ready) check("in_ready_under_stall", int'(in_ready), 0);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                od = $signed(out_data);
                if (nres < NRES) begin
                    check($sformatf("result[%0d]", nres), od, exp_res[nres]);
                    check($sformatf("out_last[%0d]", nres), int'(out_last),
                          int'(nres == NRES - 1));
                    got[nres] = od;
                end else begin
                    check("extra_result", nres, NRES - 1);
                end
                nres++;
            end
            if (done) begin
                seen_done = 1'b1;
                // Start cycle counts as cycle 1, so done lands in cycle ROW_LEN+3.
                if (full) check("done_cycle", cyc + 1, ROW_LEN + 3);
            end
        end
        start  = 1'b0;
        cfg_we = 1'b0;
        if (!aborted) begin
            check("done_seen", int'(seen_done), 1);
            check("result_count", nres, NRES);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("idle_busy", int'(busy), 0);
            check("idle_done", int'(done), 0);
        end
    endtask

    initial begin
        vecs[0] = '{w0: -1, w1: 2, w2: -1, pat: 0, relu: 0,
                    j0: 0, v0: 0, j1: 15, v1: 0, j2: 29, v2: 0};
        vecs[1] = '{w0: -1, w1: 2, w2: -1, pat: 1, relu: 0,
                    j0: 8, v0: -100, j1: 9, v1: 200, j2: 10, v2: -100};
        vecs[2] = '{w0: -1, w1: 2, w2: -1, pat: 1, relu: 1,
                    j0: 8, v0: 0, j1: 9, v1: 200, j2: 10, v2: 0};
        vecs[3] = '{w0: -128, w1: -128, w2: -128, pat: 2, relu: 0,
                    j0: 0, v0: 49152, j1: 15, v1: 49152, j2: 29, v2: 49152};
        vecs[4] = '{w0: 127, w1: 127, w2: 127, pat: 2, relu: 0,
                    j0: 0, v0: -48768, j1: 15, v1: -48768, j2: 29, v2: -48768};

        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0; relu_en = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int k = 0; k < TAPS; k++) mw[k] = 0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[v]) begin
            write_w(0, vecs[v].w0);
            write_w(1, vecs[v].w1);
            write_w(2, vecs[v].w2);
            set_pix(vecs[v].pat);
            run_row(vecs[v].relu, 0, 0, -1, -1, -1);
            check($sformatf("vec%0d spot j%0d", v, vecs[v].j0), got[vecs[v].j0], vecs[v].v0);
            check($sformatf("vec%0d spot j%0d", v, vecs[v].j1), got[vecs[v].j1], vecs[v].v1);
            check($sformatf("vec%0d spot j%0d", v, vecs[v].j2), got[vecs[v].j2], vecs[v].v2);
        end

        // Out-of-range index write must leave the bank alone.
        write_w(3, 77);
        set_pix(3);
        run_row(1'b0, 0, 0, -1, -1, -1);

        // cfg_we and start mid-row are ignored; the following row still sees {-1,2,-1}.
        write_w(0, -1);
        write_w(1, 2);
        write_w(2, -1);
        set_pix(1);
        run_row(1'b0, 0, 0, -1, 5, -1);
        run_row(1'b0, 0, 0, -1, -1, -1);
        check("after_ignored_cfg j9", got[9], 200);
        check("after_ignored_cfg j8", got[8], -100);

        // Five-cycle downstream stall plus input gaps.
        set_pix(3);
        run_row(1'b0, 30, 0, 12, -1, -1);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < TAPS; k++) write_w(k, int'($urandom_range(255)) - 128);
            set_pix(3);
            run_row(1'($urandom_range(1)), 25, 25, -1, -1, -1);
        end

        // Reset mid-row, then a clean row from cleared weights and window.
        write_w(0, 3);
        write_w(1, -2);
        write_w(2, 1);
        set_pix(3);
        run_row(1'b0, 0, 0, -1, -1, 15);
        set_pix(0);
        run_row(1'b0, 0, 0, -1, -1, -1);
        check("post_reset j0", got[0], 0);
        check("post_reset j29", got[29], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv1d_stream_engine.md
# conv1d_stream_engine

Parametrised streaming 1-D convolution engine that processes one pixel row through a run-time-loadable TAPS-wide kernel. It is the next generation of the fixed 32-pixel, 3-tap {-1,2,-1} row engine. It adds generic row length, data width and tap count, valid/ready handshakes with backpressure on both sides, and an optional ReLU output stage. It sits between the row buffer and the feature-map writer.

## Interface
- DATA_W, 8: signed pixel and weight width
- TAPS, 3: kernel length; must satisfy 2 ≤ TAPS ≤ ROW_LEN
- ROW_LEN, 32: pixels per row
- OUT_W, 18: signed result width; must satisfy OUT_W ≥ 2·DATA_W + ceil(log2(TAPS))

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  weight write strobe; honoured only in IDLE
- cfg_idx  in  max(1,$clog2(TAPS))  weight index; writes with idx ≥ TAPS are ignored
- cfg_weight  in  DATA_W signed  weight value
- relu_en  in  1  clamp negative results to 0; sampled on start
- start  in  1  begin a row; honoured only in IDLE
- in_valid  in  1  pixel valid
- in_ready  out  1  engine accepts pixel
- in_data  in  DATA_W signed  pixel
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W signed  result
- out_last  out  1  marks the final result of the row
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of row

## Operation
- Weight bank w[0..TAPS-1] resets to 0. A cfg_we write in IDLE updates w[cfg_idx] at the next edge.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start. At this transition: clear the pixel window and input count, latch relu_en.
  - RUN→DRAIN when pixel ROW_LEN-1 is accepted.
  - DRAIN→DONE when the output register is empty, or empties that cycle.
  - DONE→IDLE unconditionally. done=1 only while in DONE.
- Pixel accept condition: in_valid && in_ready.
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - Accepted pixel i (0-based) shifts into a TAPS-deep window.
- Outputs are produced only for full windows, giving ROW_LEN-TAPS+1 results. Result j = Σ_{k=0..TAPS-1} w[k]·x[j+k], computed when pixel i=j+TAPS-1 is accepted.
- Arithmetic: products are full 2·DATA_W signed and summed at OUT_W. No overflow is possible given the OUT_W constraint, so there is no saturation or wrap.
- ReLU: if latched relu_en=1 and sum<0, output 0.
- Output register: loaded on accept of pixel i ≥ TAPS-1. It holds until out_valid && out_ready. out_last=1 with result j=ROW_LEN-TAPS.
- start in any state other than IDLE is ignored, and cfg_we outside IDLE is ignored. Kernel changes therefore never affect a row in flight.
- Simultaneous output pop and pixel push in the same cycle: the register is reloaded with the new result and out_valid stays 1.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, all weights 0, state IDLE. Reset takes effect immediately and asynchronously, including mid-row; the partial row is discarded.
- Fixed latency, with every cycle counted as a rising clock edge (in-cycle):
  - start in-cycle t: busy=1 and in_ready can be 1 at t+1.
  - Pixel i accepted in-cycle t (i ≥ TAPS-1): result j valid at t+1.
- With constant in_valid=1 and out_ready=1 the engine sustains 1 pixel/cycle and the row takes ROW_LEN+3 cycles from start to done (RUN, DRAIN, DONE).
- Backpressure: out_valid && !out_ready forces in_ready=0 in the same cycle. No result is ever overwritten or dropped.
- The first TAPS-1 accepted pixels produce no output; out_valid stays 0 for them.

## Test plan
- Defaults, weights {-1,2,-1}, row x[i]=i, full throughput → 30 results, all 0. out_last on the 30th result. done at start+35 cycles.
- Same weights, impulse x[10]=100 and all other pixels 0 → result j=8 is -100, j=9 is 200, j=10 is -100, all others 0. With relu_en=1: j=8 and j=10 are 0, j=9 is 200.
- Extremes: all weights -128, all pixels -128 → every result is 49152. All weights 127, all pixels -128 → every result is -48768.
- Backpressure: out_ready held low for 5 cycles mid-row, plus random in_valid gaps → in_ready=0 during the stall, and the result sequence is identical to the no-stall run.
- Ignored controls: cfg_we writing w[1]=5 while busy, and start pulsed during RUN → current and next row use the original weights; no restart occurs.
- Async reset asserted after pixel 15, then a new start → all outputs return to their reset values immediately. The next row produces correct results from a cleared window, and weights are 0, so all results are 0.
